// File: rtl/core_input_feeder_pkg.sv
// Shared definitions for the core input feeder.
//   HashState  : 256-bit job midstate, field a in the most significant word
//   JOB_WORDS  : words per job (8 HashState words + w1, w2, w3)
//   HS_WORDS   : HashState words per job
//   word_idx_t : shadow slot index within a job
package core_input_feeder_pkg;

  localparam int unsigned JOB_WORDS = 11;
  localparam int unsigned HS_WORDS  = 8;

  typedef logic [3:0] word_idx_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } HashState;

  localparam word_idx_t LAST_IDX = word_idx_t'(JOB_WORDS - 1);

endpackage

// File: rtl/core_input_feeder_job_assembler.sv
// Job assembler: collects the 11 words of a job into shadow slots and holds
// the completed job (pending) until the top-level issue logic takes it.
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid_i       : upstream word valid
//   in_data_i        : upstream word (HashState a..h, then w1, w2, w3)
//   flush_i          : synchronous abort of a partial or pending job
//   issue_i          : the active registers take the shadow job this edge
//   in_ready_o       : a word can be accepted this cycle
//   pending_o        : a complete job waits in the shadow slots
//   shadow_hs_o      : shadow HashState (a in the top word)
//   shadow_w1/2/3_o  : shadow tail words
module job_assembler
  import core_input_feeder_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [31:0]  in_data_i,
  input  logic         flush_i,
  input  logic         issue_i,
  output logic         in_ready_o,
  output logic         pending_o,
  output logic [255:0] shadow_hs_o,
  output logic [31:0]  shadow_w1_o,
  output logic [31:0]  shadow_w2_o,
  output logic [31:0]  shadow_w3_o
);

  word_idx_t   idx_q, idx_d;
  logic        pending_q, pending_d;
  logic [31:0] slot_q [JOB_WORDS];
  logic        accept;

  // No path from in_valid: ready depends only on registered state and flush.
  assign in_ready_o = !pending_q && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign pending_o  = pending_q;

  always_comb begin
    idx_d     = idx_q;
    pending_d = pending_q;
    if (flush_i) begin
      idx_d     = '0;
      pending_d = 1'b0;
    end else if (issue_i) begin
      pending_d = 1'b0;
    end else if (accept) begin
      if (idx_q == LAST_IDX) begin
        idx_d     = '0;
        pending_d = 1'b1;
      end else begin
        idx_d = idx_q + word_idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < JOB_WORDS; i++) slot_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < JOB_WORDS; i++) begin
        if (accept && (idx_q == word_idx_t'(i))) slot_q[i] <= in_data_i;
      end
    end
  end

  always_comb begin
    shadow_hs_o = '0;
    for (int unsigned i = 0; i < HS_WORDS; i++) begin
      shadow_hs_o[255 - 32*i -: 32] = slot_q[i];
    end
  end

  assign shadow_w1_o = slot_q[HS_WORDS];
  assign shadow_w2_o = slot_q[HS_WORDS + 1];
  assign shadow_w3_o = slot_q[HS_WORDS + 2];

endmodule

// File: rtl/core_input_feeder.sv
// Core input feeder: assembles jobs from the host loader, double-buffers
// them and issues each to the hashing cores with a one-cycle newblock pulse,
// keeping at least ISSUE_GAP cycles between pulses.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream word handshake
//   in_data             : job word (HashState a..h, then w1, w2, w3)
//   flush               : synchronous abort, stops driving the cores
//   valid, newblock     : core interface job live / first cycle of job
//   hashstate, w1..w3   : core interface job data
//   jobs_issued         : newblock pulses since reset, wrapping
module core_input_feeder
  import core_input_feeder_pkg::*;
#(
  parameter int unsigned ISSUE_GAP = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             flush,
  output logic             valid,
  output logic             newblock,
  output logic [255:0]     hashstate,
  output logic [31:0]      w1,
  output logic [31:0]      w2,
  output logic [31:0]      w3,
  output logic [CNT_W-1:0] jobs_issued
);

  localparam int unsigned GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(ISSUE_GAP - 1);

  logic             pending;
  logic [255:0]     shadow_hs;
  logic [31:0]      shadow_w1, shadow_w2, shadow_w3;
  logic             issue;

  logic [GAP_W-1:0] gap_q, gap_d;
  logic             valid_q, valid_d;
  logic             newblock_q, newblock_d;
  HashState         hs_q, hs_d;
  logic [31:0]      w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  logic [CNT_W-1:0] jobs_q, jobs_d;

  job_assembler u_job_assembler (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .flush_i     (flush),
    .issue_i     (issue),
    .in_ready_o  (in_ready),
    .pending_o   (pending),
    .shadow_hs_o (shadow_hs),
    .shadow_w1_o (shadow_w1),
    .shadow_w2_o (shadow_w2),
    .shadow_w3_o (shadow_w3)
  );

  assign issue = pending && (gap_q == '0) && !flush;

  always_comb begin
    gap_d      = gap_q;
    valid_d    = valid_q;
    newblock_d = 1'b0;
    hs_d       = hs_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    w3_d       = w3_q;
    jobs_d     = jobs_q;
    if (flush) begin
      // Data registers deliberately hold; only the live/timing state clears.
      gap_d   = '0;
      valid_d = 1'b0;
    end else if (issue) begin
      hs_d       = shadow_hs;
      w1_d       = shadow_w1;
      w2_d       = shadow_w2;
      w3_d       = shadow_w3;
      valid_d    = 1'b1;
      newblock_d = 1'b1;
      gap_d      = GAP_RELOAD;
      jobs_d     = jobs_q + CNT_W'(1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q      <= '0;
      valid_q    <= 1'b0;
      newblock_q <= 1'b0;
      hs_q       <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      w3_q       <= '0;
      jobs_q     <= '0;
    end else begin
      gap_q      <= gap_d;
      valid_q    <= valid_d;
      newblock_q <= newblock_d;
      hs_q       <= hs_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      w3_q       <= w3_d;
      jobs_q     <= jobs_d;
    end
  end

  assign valid       = valid_q;
  assign newblock    = newblock_q;
  assign hashstate   = hs_q;
  assign w1          = w1_q;
  assign w2          = w2_q;
  assign w3          = w3_q;
  assign jobs_issued = jobs_q;

endmodule

// File: tb/tb_core_input_feeder.sv
// Testbench for core_input_feeder: directed scenarios plus randomized traffic
// against a job-level reference model (word queue, absolute issue times).
module tb_core_input_feeder;

  localparam int unsigned GAP  = 64;
  localparam int unsigned CNTW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_data;
  logic            flush;
  logic            valid;
  logic            newblock;
  logic [255:0]    hashstate;
  logic [31:0]     w1, w2, w3;
  logic [CNTW-1:0] jobs_issued;

  always #5 clk = ~clk;

  core_input_feeder #(.ISSUE_GAP(GAP), .CNT_W(CNTW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .flush       (flush),
    .valid       (valid),
    .newblock    (newblock),
    .hashstate   (hashstate),
    .w1          (w1),
    .w2          (w2),
    .w3          (w3),
    .jobs_issued (jobs_issued)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: jobs as word lists, spacing from absolute edge numbers.
  logic [31:0] m_words[$];
  logic [31:0] m_job [11];
  logic [31:0] m_act [11];
  bit          m_pending, m_valid, m_newblock, m_gap_free;
  int unsigned m_jobs;
  longint      m_cyc, m_last;
  logic        rdy_seen, rdy_exp;

  function automatic logic [351:0] m_bus();
    logic [351:0] r;
    for (int i = 0; i < 11; i++) r[351 - 32*i -: 32] = m_act[i];
    return r;
  endfunction

  function automatic logic [351:0] seq_bus(input logic [31:0] base);
    logic [351:0] r;
    for (int i = 0; i < 11; i++) r[351 - 32*i -: 32] = base + 32'(i);
    return r;
  endfunction

  function automatic logic [351:0] dut_bus();
    return {hashstate, w1, w2, w3};
  endfunction

  task automatic model_reset();
    m_words.delete();
    for (int i = 0; i < 11; i++) begin m_job[i] = '0; m_act[i] = '0; end
    m_pending = 0; m_valid = 0; m_newblock = 0; m_gap_free = 1; m_jobs = 0;
  endtask

  task automatic model_edge(input logic v, input logic [31:0] d, input logic f);
    bit pend_pre;
    m_cyc++;
    if (f) begin
      m_words.delete();
      m_pending = 0; m_valid = 0; m_newblock = 0; m_gap_free = 1;
    end else begin
      pend_pre = m_pending;
      if (pend_pre && (m_gap_free || (m_cyc - m_last >= longint'(GAP)))) begin
        m_act = m_job;
        m_valid = 1; m_newblock = 1; m_pending = 0;
        m_last = m_cyc; m_gap_free = 0;
        m_jobs = (m_jobs + 1) % (1 << CNTW);
      end else begin
        m_newblock = 0;
      end
      if (v && !pend_pre) begin
        m_words.push_back(d);
        if (m_words.size() == 11) begin
          for (int i = 0; i < 11; i++) m_job[i] = m_words[i];
          m_words.delete();
          m_pending = 1;
        end
      end
    end
  endtask

  // One clock: drive at negedge, capture in_ready before the edge, advance model.
  task automatic step(input logic v, input logic [31:0] d, input logic f);
    @(negedge clk);
    in_valid = v; in_data = d; flush = f;
    #1;
    rdy_seen = in_ready;
    rdy_exp  = !m_pending && !f;
    @(posedge clk);
    model_edge(v, d, f);
    #1;
  endtask

  task automatic hard_reset();
    in_valid = 0; in_data = '0; flush = 0;
    rst_n = 0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic load_seq(input logic [31:0] base);
    for (int i = 0; i < 11; i++) step(1'b1, base + 32'(i), 1'b0);
  endtask

  // Idle until newblock; an expired budget is reported as a failure.
  task automatic wait_issue(input string name, input int budget);
    int n = 0;
    while (!newblock && n < budget) begin step(1'b0, '0, 1'b0); n++; end
    tests_run++;
    if (newblock !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_timeout newblock=%b after %0d cycles, required 1", name, newblock, n);
    end
  endtask

  task automatic test_reset();
    hard_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b0);
      tests_run++;
      if ({valid, newblock, rdy_seen, jobs_issued} !== {1'b0, 1'b0, 1'b1, CNTW'(0)}) begin
        tests_failed++;
        $display("FAIL reset_idle cyc%0d got v=%b nb=%b rdy=%b jobs=%0d required 0 0 1 0",
                 i, valid, newblock, rdy_seen, jobs_issued);
      end
    end
    tests_run++;
    if (dut_bus() !== '0) begin
      tests_failed++;
      $display("FAIL reset_data got %h required 0", dut_bus());
    end
  endtask

  task automatic test_single_job();
    load_seq(32'h1);
    step(1'b0, '0, 1'b0);
    tests_run++;
    if ({newblock, valid} !== 2'b11 || dut_bus() !== seq_bus(32'h1)) begin
      tests_failed++;
      $display("FAIL single_issue got nb=%b v=%b bus=%h required 1 1 %h",
               newblock, valid, dut_bus(), seq_bus(32'h1));
    end
    step(1'b0, '0, 1'b0);
    tests_run++;
    if ({newblock, valid, jobs_issued} !== {1'b0, 1'b1, CNTW'(1)}) begin
      tests_failed++;
      $display("FAIL single_after got nb=%b v=%b jobs=%0d required 0 1 1",
               newblock, valid, jobs_issued);
    end
  endtask

  task automatic test_back_to_back();
    longint t_a, t_b;
    logic [351:0] bus_a;
    int n = 0;
    step(1'b0, '0, 1'b1);
    load_seq(32'h1000);
    wait_issue("b2b_first", 30);
    t_a = m_cyc;
    bus_a = seq_bus(32'h1000);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 32'h2000 + 32'(i), 1'b0);
      tests_run++;
      if (valid !== 1'b1 || dut_bus() !== bus_a) begin
        tests_failed++;
        $display("FAIL b2b_hold_load w%0d got v=%b bus=%h required 1 %h", i, valid, dut_bus(), bus_a);
      end
    end
    step(1'b0, '0, 1'b0);
    tests_run++;
    if (rdy_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_ready_low got %b required 0", rdy_seen);
    end
    while (!newblock && n < 100) begin
      tests_run++;
      if (valid !== 1'b1 || dut_bus() !== bus_a) begin
        tests_failed++;
        $display("FAIL b2b_hold_wait got v=%b bus=%h required 1 %h", valid, dut_bus(), bus_a);
      end
      step(1'b0, '0, 1'b0);
      n++;
    end
    t_b = m_cyc;
    tests_run++;
    if (newblock !== 1'b1 || (t_b - t_a) != longint'(GAP) || dut_bus() !== seq_bus(32'h2000)) begin
      tests_failed++;
      $display("FAIL b2b_spacing got nb=%b gap=%0d bus=%h required 1 %0d %h",
               newblock, t_b - t_a, dut_bus(), GAP, seq_bus(32'h2000));
    end
  endtask

  task automatic test_flush_partial();
    int nb_count = 0;
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 32'hDEAD0000 + 32'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 32'h100 + 32'(i), 1'b0);
      tests_run++;
      if (valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL flushp_valid_gap w%0d got %b required 0", i, valid);
      end
    end
    step(1'b0, '0, 1'b0);
    tests_run++;
    if (newblock !== 1'b1 || hashstate[255:224] !== 32'h100 || dut_bus() !== seq_bus(32'h100)) begin
      tests_failed++;
      $display("FAIL flushp_job got nb=%b bus=%h required 1 %h", newblock, dut_bus(), seq_bus(32'h100));
    end
    for (int i = 0; i < 80; i++) begin
      step(1'b0, '0, 1'b0);
      if (newblock) nb_count++;
    end
    tests_run++;
    if (nb_count != 0) begin
      tests_failed++;
      $display("FAIL flushp_single_nb extra pulses=%0d required 0", nb_count);
    end
  endtask

  task automatic test_flush_active();
    int unsigned jobs_before;
    load_seq(32'h200);
    wait_issue("flusha_setup", 100);
    jobs_before = m_jobs;
    step(1'b1, 32'hBAD0BAD0, 1'b1);
    tests_run++;
    if ({valid, newblock, rdy_seen} !== 3'b000 || jobs_issued !== CNTW'(jobs_before)) begin
      tests_failed++;
      $display("FAIL flusha_drop got v=%b nb=%b rdy=%b jobs=%0d required 0 0 0 %0d",
               valid, newblock, rdy_seen, jobs_issued, jobs_before);
    end
    load_seq(32'h300);
    step(1'b0, '0, 1'b0);
    tests_run++;
    if (newblock !== 1'b1 || dut_bus() !== seq_bus(32'h300)) begin
      tests_failed++;
      $display("FAIL flusha_nowait got nb=%b bus=%h required 1 %h", newblock, dut_bus(), seq_bus(32'h300));
    end
  endtask

  task automatic test_wrap();
    hard_reset();
    for (int j = 0; j < 17; j++) begin
      for (int i = 0; i < 11; i++) step(1'b1, $urandom, 1'b0);
      wait_issue("wrap", 100);
      tests_run++;
      if (dut_bus() !== m_bus()) begin
        tests_failed++;
        $display("FAIL wrap_data job%0d got %h required %h", j, dut_bus(), m_bus());
      end
    end
    tests_run++;
    if (jobs_issued !== CNTW'(1)) begin
      tests_failed++;
      $display("FAIL wrap_count got %0d required 1", jobs_issued);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h400 + 32'(i), 1'b0);
    @(negedge clk);
    in_valid = 0; flush = 0;
    #2;
    rst_n = 0;
    #1;
    tests_run++;
    if ({valid, newblock, in_ready, jobs_issued} !== {1'b0, 1'b0, 1'b1, CNTW'(0)} || dut_bus() !== '0) begin
      tests_failed++;
      $display("FAIL async_reset got v=%b nb=%b rdy=%b jobs=%0d bus=%h required 0 0 1 0 0",
               valid, newblock, in_ready, jobs_issued, dut_bus());
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    load_seq(32'h500);
    step(1'b0, '0, 1'b0);
    tests_run++;
    if (newblock !== 1'b1 || dut_bus() !== seq_bus(32'h500)) begin
      tests_failed++;
      $display("FAIL async_reload got nb=%b bus=%h required 1 %h", newblock, dut_bus(), seq_bus(32'h500));
    end
  endtask

  task automatic test_random();
    logic v, f;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 59) == 0);
      step(v, $urandom, f);
      tests_run++;
      if (rdy_seen !== rdy_exp || valid !== m_valid || newblock !== m_newblock ||
          jobs_issued !== CNTW'(m_jobs) || dut_bus() !== m_bus()) begin
        tests_failed++;
        $display("FAIL random cyc%0d got rdy=%b v=%b nb=%b jobs=%0d bus=%h required %b %b %b %0d %h",
                 i, rdy_seen, valid, newblock, jobs_issued, dut_bus(),
                 rdy_exp, m_valid, m_newblock, m_jobs, m_bus());
      end
    end
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_data = '0; flush = 0;
    m_cyc = 0; m_last = 0;
    model_reset();
    test_reset();
    test_single_job();
    test_back_to_back();
    test_flush_partial();
    test_flush_active();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/core_input_feeder.md
Name: core_input_feeder

Overview:
- Writer-side driver of the core input interface: drives valid, newblock, hashstate, w1, w2 and w3 into the hashing cores.
- Assembles mining jobs arriving as 32-bit words from the host loader: 8 HashState words, then w1, w2, w3.
- Double-buffers jobs (shadow + active) and issues each to the cores with a one-cycle newblock pulse.
- Enforces a minimum spacing between consecutive newblock pulses.

Parameters:
ISSUE_GAP, 64, minimum clock cycles between consecutive newblock pulses (legal range >= 1)
CNT_W, 16, width of jobs_issued counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  feeder can accept a word this cycle
in_data  input  32  job word; order: hashstate word 0..7 (HashState field order, a first), then w1, w2, w3
flush  input  1  synchronous abort: drop partial/pending job, stop driving cores
valid  output  1  core interface: job on bus is live
newblock  output  1  core interface: first cycle of a new job
hashstate  output  HashState (256)  core interface: job midstate
w1  output  32  core interface: job tail word 1
w2  output  32  core interface: job tail word 2
w3  output  32  core interface: job tail word 3
jobs_issued  output  CNT_W  count of newblock pulses since reset, wraps

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: valid=0, newblock=0, hashstate=0, w1=w2=w3=0, jobs_issued=0, in_ready=1. Internal: word index 0, pending=0, gap counter 0.
- Handshake: a word transfers on a rising edge with in_valid && in_ready.
- in_ready = !pending && !flush, combinational from registers and flush only, with no path from in_valid.
- Word index 0..10 selects the shadow slot. Index increments per transfer.
- On transfer at index 10: index wraps to 0 and pending sets.
- While pending: in_ready=0, shadow contents frozen.
- Issue occurs on the first edge where pending && gap_cnt==0 && !flush. On that edge:
  - active regs load from shadow (hashstate, w1, w2, w3);
  - valid<=1, newblock<=1;
  - pending<=0;
  - gap_cnt<=ISSUE_GAP-1;
  - jobs_issued increments, mod 2^CNT_W.
- Latency: with gap expired, outputs change on the edge after the edge accepting word 10. newblock is high exactly 1 cycle.
- Per-cycle outputs: newblock deasserts the following cycle; valid stays 1 and data is held until the next issue or flush.
- gap_cnt decrements each cycle while nonzero, saturating at 0.
- A new job may load into the shadow while the active job is live.
- Simultaneous pending-set and issue cannot happen: pending is registered, so minimum 1 cycle.
- Back-to-back issues are spaced max(ISSUE_GAP, 12) cycles apart.
- flush (synchronous, highest priority), on that edge:
  - index<=0, pending<=0, valid<=0, newblock<=0, gap_cnt<=0;
  - data registers hold their values; jobs_issued is unchanged;
  - a word presented during flush is not accepted.
- Reset mid-load or mid-issue: all state returns to reset values immediately, with no partial issue.
- Outputs are registered (no combinational path from inputs), except in_ready as stated above.

Decomposition:
- Shared package: HashState typedef (existing), JOB_WORDS=11 and HS_WORDS=8 constants, and the word-index typedef (4 bits).
- Sub-module job_assembler: index counter, shadow registers, pending flag, in_ready.
- Top: gap counter, active registers, issue logic, jobs_issued.

Test Plan:
- Reset then idle -> valid=0, newblock=0, in_ready=1, jobs_issued=0 for 20 cycles.
- Load words 0x00000001..0x0000000B with in_valid held -> 1 cycle after word 11: newblock=1, valid=1, hashstate.a=1 .. .h=8, w1=9, w2=0xA, w3=0xB; next cycle newblock=0, valid=1, jobs_issued=1.
- ISSUE_GAP=64, second job loaded immediately after the first -> in_ready=0 after its 11th word; second newblock exactly 64 cycles after the first; first job's data held throughout.
- Load 5 words, flush 1 cycle, then a full job 0x100..0x10A -> hashstate.a=0x100 (no stale words), valid=0 during the gap, single newblock.
- Assert flush while a job is active -> valid=0 next cycle; jobs_issued unchanged; the next job issues with no wait (gap_cnt=0).
- CNT_W=4, issue 17 jobs -> jobs_issued=1. Also: assert rst_n=0 asynchronously mid-load -> all outputs at reset values before the next edge.
